// File: rtl/utils_pkg.sv
// Shared core types: LSU op/width encodings plus write-back stage state and hold-buffer payload.
package utils_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      NO_LSU,
      LSU_LOAD,
      LSU_STORE
   } lsu_op_typ_t;

   typedef enum logic [2:0] {
      LSU_B,
      LSU_H,
      LSU_W,
      LSU_BU,
      LSU_HU
   } lsu_w_t;

   typedef enum logic [1:0] {
      PASS,
      HOLD,
      DRAIN
   } wb_state_t;

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  data;
   } s_wb_hold_t;

endpackage

// File: rtl/wb_stg_load_align.sv
// Load data alignment: shift the word-aligned bus data down to the access offset,
// sign/zero-extend by width, and flag accesses not aligned to their natural size.
module load_align
   import utils_pkg::*;
(
   input  lsu_w_t          width_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] data_o,
   output logic            misalign_o
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted    = data_i >> {addr_lo_i, 3'b000};
      data_o     = shifted;
      misalign_o = 1'b0;
      case (width_i)
         LSU_B:  data_o = {{24{shifted[7]}}, shifted[7:0]};
         LSU_BU: data_o = {24'b0, shifted[7:0]};
         LSU_H: begin
            data_o     = {{16{shifted[15]}}, shifted[15:0]};
            misalign_o = addr_lo_i[0];
         end
         LSU_HU: begin
            data_o     = {16'b0, shifted[15:0]};
            misalign_o = addr_lo_i[0];
         end
         LSU_W:   misalign_o = (addr_lo_i != 2'b00);
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/wb_stg.sv
// Write-back stage: arbitrates held ALU result, aligned load data and new ALU result onto the
// single register-file write port. Optional NOX_WB_FWD_EN adds a combinational bypass of the winner.
module wb_stg
   import utils_pkg::*;
#(
   parameter int unsigned SUPPORT_DEBUG = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              exe_valid_i,
   input  logic [REG_W-1:0]  exe_rd_i,
   input  logic [XLEN-1:0]   exe_result_i,
   input  lsu_op_typ_t       lsu_op_i,
   input  lsu_w_t            lsu_width_i,
   input  logic [1:0]        lsu_addr_lo_i,
   input  logic [REG_W-1:0]  lsu_rd_i,
   input  logic [XLEN-1:0]   lsu_data_i,
   input  logic              lsu_data_valid_i,
   output logic              wb_bp_o,
   output logic              rf_we_o,
   output logic [REG_W-1:0]  rf_addr_o,
   output logic [XLEN-1:0]   rf_data_o,
   output logic              misalign_o,
   output logic [1:0]        misalign_addr_lo_o,
`ifdef NOX_WB_FWD_EN
   output logic              fwd_vld_o,
   output logic [REG_W-1:0]  fwd_rd_o,
   output logic [XLEN-1:0]   fwd_data_o,
`endif
   output logic [XLEN-1:0]   dbg_last_wb_o
);

   wb_state_t        st_q, st_d;
   s_wb_hold_t       hold_q, hold_d;
   s_wb_hold_t       ld_q, ld_d;
   s_wb_hold_t       win, ld_now, alu_now;
   logic [XLEN-1:0]  al_data;
   logic             al_mis;
   logic             ld_cap, ld_wr, ld_mis, exe_ok;
   logic             rf_we_d;
   logic             rf_we_q;
   logic [REG_W-1:0] rf_addr_q;
   logic [XLEN-1:0]  rf_data_q;
   logic             misalign_q;
   logic [1:0]       misalign_lo_q;

   load_align u_load_align (
      .width_i    (lsu_width_i),
      .addr_lo_i  (lsu_addr_lo_i),
      .data_i     (lsu_data_i),
      .data_o     (al_data),
      .misalign_o (al_mis)
   );

   // A misaligned load never competes for the write port; it only raises the trap.
   assign ld_cap  = (lsu_op_i == LSU_LOAD) && lsu_data_valid_i;
   assign ld_wr   = ld_cap && !al_mis;
   assign ld_mis  = ld_cap && al_mis;
   assign exe_ok  = exe_valid_i && (exe_rd_i != '0) && (st_q == PASS);
   assign ld_now  = '{vld: ld_wr, rd: lsu_rd_i, data: al_data};
   assign alu_now = '{vld: exe_ok, rd: exe_rd_i, data: exe_result_i};
   assign wb_bp_o = (st_q != PASS);

   // Arbitration and next state: buffered entry first, then load, then ALU.
   always_comb begin
      st_d   = st_q;
      hold_d = '0;
      ld_d   = '0;
      win    = '0;
      case (st_q)
         PASS: begin
            if (ld_wr) begin
               win = ld_now;
               if (exe_ok) begin
                  hold_d = alu_now;
                  st_d   = HOLD;
               end
            end else begin
               win = alu_now;
            end
         end
         HOLD: begin
            win = hold_q;
            if (ld_wr) begin
               ld_d = ld_now;
               st_d = DRAIN;
            end else begin
               st_d = PASS;
            end
         end
         DRAIN: begin
            win = ld_q;
            if (ld_wr) begin
               ld_d = ld_now;
            end else begin
               st_d = PASS;
            end
         end
         default: st_d = PASS;
      endcase
   end

   assign rf_we_d = win.vld && (win.rd != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q          <= PASS;
         hold_q        <= '0;
         ld_q          <= '0;
         rf_we_q       <= 1'b0;
         rf_addr_q     <= '0;
         rf_data_q     <= '0;
         misalign_q    <= 1'b0;
         misalign_lo_q <= '0;
      end else begin
         st_q       <= st_d;
         hold_q     <= hold_d;
         ld_q       <= ld_d;
         rf_we_q    <= rf_we_d;
         misalign_q <= ld_mis;
         if (rf_we_d) begin
            rf_addr_q <= win.rd;
            rf_data_q <= win.data;
         end
         if (ld_mis) begin
            misalign_lo_q <= lsu_addr_lo_i;
         end
      end
   end

   assign rf_we_o            = rf_we_q;
   assign rf_addr_o          = rf_addr_q;
   assign rf_data_o          = rf_data_q;
   assign misalign_o         = misalign_q;
   assign misalign_addr_lo_o = misalign_lo_q;

`ifdef NOX_WB_FWD_EN
   assign fwd_vld_o  = rf_we_d;
   assign fwd_rd_o   = win.rd;
   assign fwd_data_o = win.data;
`endif

   generate
      if (SUPPORT_DEBUG != 0) begin : g_dbg
         logic [XLEN-1:0] dbg_q;
         always_ff @(posedge clk) begin
            if (!rst) begin
               dbg_q <= '0;
            end else if (rf_we_d) begin
               dbg_q <= win.data;
            end
         end
         assign dbg_last_wb_o = dbg_q;
      end else begin : g_no_dbg
         assign dbg_last_wb_o = '0;
      end
   endgenerate

endmodule
